// File: rtl/store_pkg.sv
// Shared types and constants for the store alignment unit.
//   st_op_t : store opcode encoding carried on req_op (values 5..7 are illegal)
//   state_t : bus sequencing states
//   lane_mask(): expands a byte-enable vector into a 32-bit bit mask
package store_pkg;

    localparam int OFS_W = 2;
    localparam int LANES = 4;

    typedef enum logic [2:0] {
        ST_SB  = 3'd0,
        ST_SH  = 3'd1,
        ST_SW  = 3'd2,
        ST_SWL = 3'd3,
        ST_SWR = 3'd4
    } st_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    function automatic logic [8*LANES-1:0] lane_mask(input logic [LANES-1:0] be);
        logic [8*LANES-1:0] m;
        m = {(8*LANES){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Request + data-memory bus bundle for store_align_unit.
//   master : view taken by store_align_unit (accepts requests, masters the memory bus)
//   slave  : view taken by the environment (issues requests, serves memory)
// req_op uses the store_pkg::st_op_t encoding; it is kept as a plain 3-bit vector
// so that illegal encodings can be presented and rejected.
interface store_align_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_rt;
    logic [31:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        done;
    logic        misaligned;

    modport master (
        input  req_valid, req_op, req_addr, req_rt, mem_readdata, mem_waitrequest,
        output req_ready, mem_address, mem_write, mem_read, mem_byteenable,
               mem_writedata, done, misaligned
    );

    modport slave (
        output req_valid, req_op, req_addr, req_rt, mem_readdata, mem_waitrequest,
        input  req_ready, mem_address, mem_write, mem_read, mem_byteenable,
               mem_writedata, done, misaligned
    );

endinterface

// File: rtl/store_lane_gen.sv
// Combinational lane generator: maps a store opcode, byte offset and rt value
// onto little-endian byte enables and lane-aligned write data.
// Ports:
//   op         in  3   store opcode (store_pkg::st_op_t encoding)
//   ofs        in  2   byte offset within the word
//   rt         in  32  register value to store
//   be         out 4   byte enables, lane i = data[8i+7:8i]
//   data       out 32  lane-aligned write data
//   misaligned out 1   request cannot be issued (bad alignment or illegal op)
module store_lane_gen
    import store_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [OFS_W-1:0] ofs,
    input  logic [31:0]      rt,
    output logic [LANES-1:0] be,
    output logic [31:0]      data,
    output logic             misaligned
);

    // Decode opcode into lane mask and shifted data
    always_comb begin
        be         = 4'b0000;
        data       = 32'h0000_0000;
        misaligned = 1'b0;
        case (op)
            ST_SB: begin
                be   = 4'b0001 << ofs;
                data = {4{rt[7:0]}};
            end
            ST_SH: begin
                be         = 4'b0011 << ofs;
                data       = {2{rt[15:0]}};
                misaligned = ofs[0];
            end
            ST_SW: begin
                be         = 4'b1111;
                data       = rt;
                misaligned = (ofs != 2'b00);
            end
            ST_SWL: begin
                // lanes 0..ofs; 4'b0010<<3 wraps to 0 so the decrement yields 4'b1111
                be   = (4'b0010 << ofs) - 4'b0001;
                // 3-ofs equals ~ofs for a 2-bit offset
                data = rt >> {~ofs, 3'b000};
            end
            ST_SWR: begin
                be   = 4'b1111 << ofs;
                data = rt << {ofs, 3'b000};
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts one MIPS store (SB/SH/SW/SWL/SWR), aligns data
// and byte enables to the word lanes, and issues it on a wait-request memory bus.
// With USE_RMW=1 the word is read first, the store lanes are merged in, and the
// full word is written with all byte enables set.
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous active-high reset
//   bus    master view of store_align_unit_if (request handshake, memory bus,
//          done / misaligned pulses); all outputs are registered
module store_align_unit
    import store_pkg::*;
#(
    parameter int unsigned USE_RMW = 0
)(
    input  logic                clk,
    input  logic                reset,
    store_align_unit_if.master  bus
);

    logic [LANES-1:0] gen_be_s;
    logic [31:0]      gen_data_s;
    logic             gen_mis_s;

    state_t           state_r, state_s;
    logic [LANES-1:0] cap_be_r, cap_be_s;
    logic [31:0]      cap_data_r, cap_data_s;
    logic [31:0]      merged_s;
    logic             accept_s;

    logic             req_ready_r, req_ready_s;
    logic [31:0]      mem_address_r, mem_address_s;
    logic             mem_write_r, mem_write_s;
    logic             mem_read_r, mem_read_s;
    logic [3:0]       mem_byteenable_r, mem_byteenable_s;
    logic [31:0]      mem_writedata_r, mem_writedata_s;
    logic             done_r, done_s;
    logic             misaligned_r, misaligned_s;

    store_lane_gen u_lane_gen (
        .op         (bus.req_op),
        .ofs        (bus.req_addr[1:0]),
        .rt         (bus.req_rt),
        .be         (gen_be_s),
        .data       (gen_data_s),
        .misaligned (gen_mis_s)
    );

    assign accept_s = bus.req_valid && req_ready_r;

    // Next-state and next-output logic; every output holds unless a transition changes it
    always_comb begin
        state_s          = state_r;
        cap_be_s         = cap_be_r;
        cap_data_s       = cap_data_r;
        mem_address_s    = mem_address_r;
        mem_write_s      = mem_write_r;
        mem_read_s       = mem_read_r;
        mem_byteenable_s = mem_byteenable_r;
        mem_writedata_s  = mem_writedata_r;
        done_s           = 1'b0;
        misaligned_s     = 1'b0;
        merged_s         = (bus.mem_readdata & ~lane_mask(cap_be_r))
                         | (cap_data_r & lane_mask(cap_be_r));
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (gen_mis_s) begin
                        // rejected request never touches the bus
                        misaligned_s = 1'b1;
                    end else begin
                        cap_be_s        = gen_be_s;
                        cap_data_s      = gen_data_s;
                        mem_address_s   = {bus.req_addr[31:2], 2'b00};
                        mem_writedata_s = gen_data_s;
                        if (USE_RMW != 0) begin
                            state_s          = S_READ;
                            mem_read_s       = 1'b1;
                            mem_byteenable_s = 4'b1111;
                        end else begin
                            state_s          = S_WRITE;
                            mem_write_s      = 1'b1;
                            mem_byteenable_s = gen_be_s;
                        end
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (!bus.mem_waitrequest) begin
                    // readdata is only valid in this cycle, so merge it now
                    state_s         = S_WRITE;
                    mem_read_s      = 1'b0;
                    mem_write_s     = 1'b1;
                    mem_writedata_s = merged_s;
                end else begin
                    state_s = S_READ;
                end
            end
            S_WRITE: begin
                if (!bus.mem_waitrequest) begin
                    state_s     = S_IDLE;
                    mem_write_s = 1'b0;
                    done_s      = 1'b1;
                end else begin
                    state_s = S_WRITE;
                end
            end
            default: begin
                state_s     = S_IDLE;
                mem_write_s = 1'b0;
                mem_read_s  = 1'b0;
            end
        endcase
        req_ready_s = (state_s == S_IDLE);
    end

    // State, capture and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= S_IDLE;
            cap_be_r         <= 4'b0000;
            cap_data_r       <= 32'h0000_0000;
            req_ready_r      <= 1'b1;
            mem_address_r    <= 32'h0000_0000;
            mem_write_r      <= 1'b0;
            mem_read_r       <= 1'b0;
            mem_byteenable_r <= 4'b0000;
            mem_writedata_r  <= 32'h0000_0000;
            done_r           <= 1'b0;
            misaligned_r     <= 1'b0;
        end else begin
            state_r          <= state_s;
            cap_be_r         <= cap_be_s;
            cap_data_r       <= cap_data_s;
            req_ready_r      <= req_ready_s;
            mem_address_r    <= mem_address_s;
            mem_write_r      <= mem_write_s;
            mem_read_r       <= mem_read_s;
            mem_byteenable_r <= mem_byteenable_s;
            mem_writedata_r  <= mem_writedata_s;
            done_r           <= done_s;
            misaligned_r     <= misaligned_s;
        end
    end

    assign bus.req_ready      = req_ready_r;
    assign bus.mem_address    = mem_address_r;
    assign bus.mem_write      = mem_write_r;
    assign bus.mem_read       = mem_read_r;
    assign bus.mem_byteenable = mem_byteenable_r;
    assign bus.mem_writedata  = mem_writedata_r;
    assign bus.done           = done_r;
    assign bus.misaligned     = misaligned_r;

endmodule
